// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC register and one-outstanding instruction fetch sequencer
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_cur,
    input  logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        misalign_trap,
    output logic        halted
);
    typedef enum logic [2:0] {FETCH, WAIT, OUT, DROP, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q, instr_q, ipc_q;
    logic        valid_q, trap_q, halted_q;
    logic        fire, outstanding, misalign;

    assign imem_req    = rst_n && state_q == FETCH && !stall;
    assign fire        = imem_req && imem_gnt;
    // A grant now, or a request not yet answered, leaves a response in flight that must be drained.
    assign outstanding = fire || ((state_q == WAIT || state_q == DROP) && !imem_rvalid);
    assign misalign    = redirect_target[1:0] != 2'b00;

    assign pc_cur        = pc_q;
    assign imem_addr     = pc_q;
    assign if_valid      = valid_q;
    assign if_instr      = instr_q;
    assign if_pc         = ipc_q;
    assign misalign_trap = trap_q;
    assign halted        = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            trap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            trap_q <= 1'b0;
            if (state_q != HALT) begin
                if (halt) begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                    valid_q  <= 1'b0;
                end else if (redirect_valid) begin
                    pc_q    <= redirect_target;
                    valid_q <= 1'b0;
                    if (misalign) begin
                        trap_q   <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        state_q <= outstanding ? DROP : FETCH;
                    end
                end else begin
                    case (state_q)
                        FETCH: if (fire) state_q <= WAIT;
                        WAIT: if (imem_rvalid) begin
                            instr_q <= imem_rdata;
                            ipc_q   <= pc_q;
                            valid_q <= 1'b1;
                            pc_q    <= pc_plus4;
                            state_q <= OUT;
                        end
                        OUT: if (if_ready && !stall) begin
                            valid_q <= 1'b0;
                            state_q <= FETCH;
                        end
                        DROP: if (imem_rvalid) state_q <= FETCH;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
